// File: rtl/impl_window_sched.sv
// Attempt scheduler for antecedent |-> ##[MIN_DLY:MAX_DLY] (consequent && data == tag).
// Optional macro IMPL_SCHED_DISABLE_IFF_EN adds disable_i with disable-iff semantics.
module impl_window_sched #(
    parameter int SLOTS   = 4,
    parameter int MIN_DLY = 3,
    parameter int MAX_DLY = 10,
    parameter int DW      = 8,
    localparam int CW     = $clog2(SLOTS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ante_i,
    input  logic [DW-1:0] ante_tag_i,
    input  logic          cons_vld_i,
    input  logic [DW-1:0] cons_data_i,
`ifdef IMPL_SCHED_DISABLE_IFF_EN
    input  logic          disable_i,
`endif
    output logic [CW-1:0] pass_cnt_o,
    output logic [CW-1:0] fail_cnt_o,
    output logic          overflow_o,
    output logic [CW-1:0] active_o
);

    localparam logic [7:0] MIN_A = 8'(MIN_DLY);
    localparam logic [7:0] MAX_A = 8'(MAX_DLY);

    typedef enum logic {FREE = 1'b0, ARMED = 1'b1} slot_st_t;

    slot_st_t          r_st  [SLOTS];
    logic [7:0]        r_age [SLOTS];
    logic [DW-1:0]     r_tag [SLOTS];
    logic [CW-1:0]     r_pass_cnt;
    logic [CW-1:0]     r_fail_cnt;
    logic [CW-1:0]     r_active;
    logic              r_overflow;

    logic [SLOTS-1:0]  w_match;
    logic [SLOTS-1:0]  w_fail;
    logic [SLOTS-1:0]  w_alloc;
    logic [SLOTS-1:0]  w_armed_nxt;
    logic              w_found;
    logic              w_drop;
    logic              w_kill;

`ifdef IMPL_SCHED_DISABLE_IFF_EN
    assign w_kill = rst | disable_i;
`else
    assign w_kill = rst;
`endif

    function automatic logic [CW-1:0] popcnt(input logic [SLOTS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < SLOTS; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // Resolve every slot first, then hand the antecedent to the lowest slot free afterwards
    always_comb begin
        w_match     = '0;
        w_fail      = '0;
        w_alloc     = '0;
        w_armed_nxt = '0;
        w_found     = 1'b0;
        w_drop      = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            w_match[i] = (r_st[i] == ARMED) && (r_age[i] >= MIN_A) && (r_age[i] <= MAX_A)
                         && cons_vld_i && (cons_data_i == r_tag[i]);
            w_fail[i]  = (r_st[i] == ARMED) && (r_age[i] == MAX_A) && !w_match[i];
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (ante_i && !w_kill && !w_found &&
                ((r_st[i] == FREE) || w_match[i] || w_fail[i])) begin
                w_alloc[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        w_drop = ante_i && !w_kill && !w_found;
        for (int i = 0; i < SLOTS; i++) begin
            w_armed_nxt[i] = w_alloc[i] | ((r_st[i] == ARMED) & ~w_match[i] & ~w_fail[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_kill) begin
            for (int i = 0; i < SLOTS; i++) r_st[i] <= FREE;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_overflow <= 1'b0;
            r_active   <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) r_st[i] <= w_armed_nxt[i] ? ARMED : FREE;
            r_pass_cnt <= popcnt(w_match);
            r_fail_cnt <= popcnt(w_fail);
            r_overflow <= w_drop;
            r_active   <= popcnt(w_armed_nxt);
        end
    end

    // Age and tag are only meaningful while the slot is ARMED, so they carry no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (w_alloc[i]) begin
                r_age[i] <= 8'd1;
                r_tag[i] <= ante_tag_i;
            end else if (r_st[i] == ARMED) begin
                r_age[i] <= r_age[i] + 8'd1;
            end
        end
    end

    assign pass_cnt_o = r_pass_cnt;
    assign fail_cnt_o = r_fail_cnt;
    assign overflow_o = r_overflow;
    assign active_o   = r_active;

endmodule

// File: tb/tb_impl_window_sched.sv
// Bench for impl_window_sched: directed scenarios plus random traffic vs an elapsed-time model.
module tb_impl_window_sched;

    localparam int SLOTS = 4;
    localparam int MIN_DLY = 3;
    localparam int MAX_DLY = 10;
    localparam int DW = 8;
    localparam int CW = $clog2(SLOTS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ante_i = 1'b0;
    logic [DW-1:0] ante_tag_i = '0;
    logic          cons_vld_i = 1'b0;
    logic [DW-1:0] cons_data_i = '0;
    logic          disable_i = 1'b0;
    logic [CW-1:0] pass_cnt_o, fail_cnt_o, active_o;
    logic          overflow_o;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: each attempt remembers the edge it was launched on
    bit      m_v     [SLOTS];
    int      m_start [SLOTS];
    int      m_tag   [SLOTS];
    int      cyc = 0;
    int      e_pass, e_fail, e_ovf, e_act;

    always #5 clk = ~clk;

    impl_window_sched #(.SLOTS(SLOTS), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ante_i      (ante_i),
        .ante_tag_i  (ante_tag_i),
        .cons_vld_i  (cons_vld_i),
        .cons_data_i (cons_data_i),
`ifdef IMPL_SCHED_DISABLE_IFF_EN
        .disable_i   (disable_i),
`endif
        .pass_cnt_o  (pass_cnt_o),
        .fail_cnt_o  (fail_cnt_o),
        .overflow_o  (overflow_o),
        .active_o    (active_o)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic step(input bit a, input int tag, input bit cv, input int cd,
                        input bit rs, input bit dis);
        bit kill;
        bit done;
        int el;
        rst         = rs;
        disable_i   = dis;
        ante_i      = a;
        ante_tag_i  = DW'(tag);
        cons_vld_i  = cv;
        cons_data_i = DW'(cd);
        @(posedge clk);
`ifdef IMPL_SCHED_DISABLE_IFF_EN
        kill = rs || dis;
`else
        kill = rs;
`endif
        e_pass = 0; e_fail = 0; e_ovf = 0; e_act = 0;
        if (kill) begin
            for (int i = 0; i < SLOTS; i++) m_v[i] = 1'b0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (m_v[i]) begin
                    el = cyc - m_start[i];
                    if (cv && cd == m_tag[i] && el >= MIN_DLY && el <= MAX_DLY) begin
                        e_pass++;
                        m_v[i] = 1'b0;
                    end else if (el == MAX_DLY) begin
                        e_fail++;
                        m_v[i] = 1'b0;
                    end
                end
            end
            if (a) begin
                done = 1'b0;
                for (int i = 0; i < SLOTS; i++) begin
                    if (!done && !m_v[i]) begin
                        m_v[i] = 1'b1;
                        m_start[i] = cyc;
                        m_tag[i] = tag;
                        done = 1'b1;
                    end
                end
                if (!done) e_ovf = 1;
            end
            for (int i = 0; i < SLOTS; i++) if (m_v[i]) e_act++;
        end
        cyc++;
        #1;
        chk("pass_cnt", 32'(pass_cnt_o), 32'(e_pass));
        chk("fail_cnt", 32'(fail_cnt_o), 32'(e_fail));
        chk("overflow", 32'(overflow_o), 32'(e_ovf));
        chk("active",   32'(active_o),   32'(e_act));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < SLOTS; i++) m_v[i] = 1'b0;
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("reset_pass", 32'(pass_cnt_o), 0);
        chk("reset_active", 32'(active_o), 0);

        // First-cycle pass at age MIN_DLY
        idle(5);
        step(1, 8'h2A, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 8'h2A, 0, 0);
        chk("s1_pass", 32'(pass_cnt_o), 1);
        chk("s1_active", 32'(active_o), 0);

        // Early match is ignored, attempt fails at MAX_DLY
        step(1, 8'h2A, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 8'h2A, 0, 0);
        idle(8);
        chk("s2_fail", 32'(fail_cnt_o), 1);
        chk("s2_pass", 32'(pass_cnt_o), 0);

        // One consequent satisfies two attempts in parallel
        step(1, 8'h11, 0, 0, 0, 0);
        step(1, 8'h11, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 8'h11, 0, 0);
        chk("s3_pass2", 32'(pass_cnt_o), 2);
        idle(2);

        // Pool exhaustion and drop
        for (int k = 0; k < 5; k++) step(1, 8'h40 + k, 0, 0, 0, 0);
        chk("s4_ovf", 32'(overflow_o), 1);
        chk("s4_active", 32'(active_o), 4);
        idle(12);
        chk("s4_drained", 32'(active_o), 0);

        // Mid-operation reset discards attempts silently
        for (int k = 0; k < 3; k++) step(1, 8'h77, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 8'h77, 1, 0);
        chk("s5_active", 32'(active_o), 0);
        chk("s5_pass", 32'(pass_cnt_o), 0);
        idle(12);

`ifdef IMPL_SCHED_DISABLE_IFF_EN
        for (int k = 0; k < 3; k++) step(1, 8'h33, 0, 0, 0, 0);
        idle(2);
        step(1, 8'h33, 1, 8'h33, 0, 1);
        chk("dis_pass", 32'(pass_cnt_o), 0);
        chk("dis_active", 32'(active_o), 0);
        step(1, 8'h5A, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 8'h5A, 0, 0);
        chk("dis_after_pass", 32'(pass_cnt_o), 1);
        idle(12);
`endif

        for (int k = 0; k < 2000; k++) begin
            bit a, cv, rs, dis;
            a   = ($urandom_range(0, 99) < 45);
            cv  = ($urandom_range(0, 99) < 50);
            rs  = ($urandom_range(0, 199) == 0);
            dis = 1'b0;
`ifdef IMPL_SCHED_DISABLE_IFF_EN
            dis = ($urandom_range(0, 149) == 0);
`endif
            step(a, $urandom_range(0, 3), cv, $urandom_range(0, 3), rs, dis);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
